// File: rtl/bsg_link_sdr_credit_tx.sv
// Credit-based link transmitter: serializes width_p words into LSB-first flits; latency 1 from accept to flit 0.
// ready_o drops when credits run out or a word is still mid-serialization; link side has no backpressure.
module bsg_link_sdr_credit_tx #(
    parameter int width_p                         = 64,
    parameter int channel_width_p                 = 16,
    parameter int lg_fifo_depth_p                 = 6,
    parameter int lg_credit_to_token_decimation_p = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [channel_width_p-1:0] link_data_o,
    output logic                       link_valid_o,
    input  logic                       token_i,
    output logic [lg_fifo_depth_p:0]   credit_o,
    output logic                       error_o
);
    localparam int N     = width_p / channel_width_p;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int CRD_W = lg_fifo_depth_p + 1;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [CRD_W:0]   CMAX = (CRD_W + 1)'(2 ** lg_fifo_depth_p);
    localparam logic [CRD_W:0]   CRET = (CRD_W + 1)'(2 ** lg_credit_to_token_decimation_p);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                     state_q;
    logic [CNT_W-1:0]           flit_cnt_q;
    logic [width_p-1:0]         shift_q;
    logic [channel_width_p-1:0] link_data_q;
    logic                       link_valid_q;
    logic [CRD_W-1:0]           credit_q;
    logic                       error_q;

    logic             accept;
    logic [CRD_W:0]   credit_sum;
    logic [CRD_W-1:0] credit_d;
    logic             credit_ovf;

    // A new word may be taken on the last flit of the current one, giving gapless streaming.
    assign ready_o = ~reset_i & (credit_q != '0) & ((state_q == IDLE) | (flit_cnt_q == LAST));
    assign accept  = valid_i & ready_o;

    // One extra bit of headroom so a token arriving near full credit is seen as overflow.
    always_comb begin
        credit_sum = {1'b0, credit_q} - (CRD_W + 1)'(accept) + (token_i ? CRET : '0);
        credit_ovf = (credit_sum > CMAX);
        credit_d   = credit_ovf ? CMAX[CRD_W-1:0] : credit_sum[CRD_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            flit_cnt_q   <= '0;
            shift_q      <= '0;
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
            credit_q     <= CMAX[CRD_W-1:0];
            error_q      <= 1'b0;
        end else begin
            credit_q <= credit_d;
            if (credit_ovf) begin
                error_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        link_data_q  <= data_i[channel_width_p-1:0];
                        shift_q      <= data_i >> channel_width_p;
                        flit_cnt_q   <= '0;
                        link_valid_q <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (flit_cnt_q != LAST) begin
                        link_data_q <= shift_q[channel_width_p-1:0];
                        shift_q     <= shift_q >> channel_width_p;
                        flit_cnt_q  <= flit_cnt_q + CNT_W'(1);
                    end else if (accept) begin
                        link_data_q  <= data_i[channel_width_p-1:0];
                        shift_q      <= data_i >> channel_width_p;
                        flit_cnt_q   <= '0;
                    end else begin
                        // link_data_q deliberately holds the last flit while idle
                        link_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign link_data_o  = link_data_q;
    assign link_valid_o = link_valid_q;
    assign credit_o     = {1'b0, credit_q[CRD_W-2:0]} | (credit_q[CRD_W-1] ? CMAX[CRD_W-1:0] : '0);
    assign error_o      = error_q;
endmodule

// File: tb/tb_bsg_link_sdr_credit_tx.sv
// Randomized and directed bench for bsg_link_sdr_credit_tx against a flit-queue / credit-count model.
module tb_bsg_link_sdr_credit_tx;
    localparam int W    = 64;
    localparam int CW   = 16;
    localparam int N    = W / CW;
    localparam int CMAX = 64;
    localparam int CRET = 8;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [CW-1:0] link_data_o;
    logic          link_valid_o;
    logic          token_i = 1'b0;
    logic [6:0]    credit_o;
    logic          error_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: flits still owed to the link, what the link shows now, credit count.
    logic [CW-1:0] pend[$];
    logic [CW-1:0] m_data;
    bit            m_vld;
    int            m_credit;
    bit            m_err;

    bsg_link_sdr_credit_tx #(
        .width_p(W), .channel_width_p(CW), .lg_fifo_depth_p(6), .lg_credit_to_token_decimation_p(3)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .link_data_o(link_data_o), .link_valid_o(link_valid_o), .token_i(token_i),
        .credit_o(credit_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from a negedge, check ready, advance model, check outputs at next negedge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic tok, input logic rst);
        bit mr, acc;
        valid_i = v; data_i = d; token_i = tok; reset_i = rst;
        #1;
        mr = !rst && (m_credit != 0) && (pend.size() == 0);
        chk("ready", ready_o, mr);
        acc = v && mr;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_data = '0; m_vld = 0; m_credit = CMAX; m_err = 0;
        end else begin
            m_credit = m_credit - (acc ? 1 : 0) + (tok ? CRET : 0);
            if (m_credit > CMAX) begin
                m_credit = CMAX;
                m_err = 1;
            end
            if (acc) for (int i = 0; i < N; i++) pend.push_back(d[i*CW +: CW]);
            if (pend.size() != 0) begin
                m_data = pend.pop_front();
                m_vld = 1;
            end else begin
                m_vld = 0;
            end
        end
        @(negedge clk);
        chk("link_valid", link_valid_o, m_vld);
        chk("link_data", link_data_o, m_data);
        chk("credit", credit_o, m_credit);
        chk("error", error_o, m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [CW-1:0] t1[4];
        logic [W-1:0]  w;
        t1[0] = 16'hCDEF; t1[1] = 16'h89AB; t1[2] = 16'h4567; t1[3] = 16'h0123;
        m_credit = CMAX; m_err = 0; m_vld = 0; m_data = '0;
        @(negedge clk);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("rst_credit", credit_o, 7'd64);
        chk("rst_valid", link_valid_o, 1'b0);
        chk("rst_data", link_data_o, 16'h0);

        // Single word, explicit flits
        cyc(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk("t1_flit_vld", link_valid_o, 1'b1);
            chk("t1_flit", link_data_o, t1[i]);
            idle(1);
        end
        chk("t1_end_vld", link_valid_o, 1'b0);
        chk("t1_credit", credit_o, 7'd63);

        // Ten words back-to-back with valid held high
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 37; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        idle(5);
        chk("t2_credit", credit_o, 7'd54);

        // Exhaust credits, then one token
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 262; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("t3_credit0", credit_o, 7'd0);
        chk("t3_ready0", ready_o, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t3_credit8", credit_o, 7'd8);
        #1 chk("t3_ready1", ready_o, 1'b1);

        // Accept and token together at credit 5
        for (int i = 0; i < 12; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        idle(6);
        chk("t4_credit5", credit_o, 7'd5);
        cyc(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        chk("t4_credit12", credit_o, 7'd12);
        idle(5);

        // Overflow saturates and sets sticky error
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        idle(6);
        chk("t5_credit60", credit_o, 7'd60);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t5_sat", credit_o, 7'd64);
        chk("t5_err", error_o, 1'b1);
        idle(4);
        chk("t5_err_sticky", error_o, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t5_err_clr", error_o, 1'b0);

        // Reset while flit 2 is on the link
        cyc(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0);
        idle(2);
        chk("t6_flit2", link_data_o, 16'hBBBB);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t6_vld0", link_valid_o, 1'b0);
        chk("t6_credit", credit_o, 7'd64);
        idle(4);
        chk("t6_no_flits", link_valid_o, 1'b0);
        cyc(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        chk("t6_clean_f0", link_data_o, 16'h4444);
        idle(5);

        // Random traffic, tokens and occasional resets
        for (int i = 0; i < 3000; i++) begin
            w = {$urandom, $urandom};
            cyc(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 499) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
